rxll_ll: RTL and testbench
==========================

# rxll_ll

Receive-side LocalLink source stage that sits directly downstream of the SATA receive link-layer FIFO, in the read clock domain. It pops 36-bit FWFT FIFO words and re-emits them as a 32-bit LocalLink frame stream with active-low framing. Frames are gated so a transfer only starts when a complete frame is buffered, or when enough data is buffered in cut-through mode. Malformed or oversize frames are discarded, and frame and drop statistics are kept.

## Interface
- C_MAX_WORDS, 2049: maximum dwords per frame (FIS header plus 8 KB payload); range 2..65535.
- C_CNT_WIDTH, 16: width of the statistics counters.
- clk  in  1  FIFO read clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- fifo_do  in  36  FIFO word: [31:0] data, [32] reserved (ignored), [33] crc_err, [34] eof, [35] sof.
- fifo_empty  in  1  FIFO empty. When low, fifo_do is valid (FWFT).
- fifo_almost_empty  in  1  FIFO almost-empty flag.
- fifo_eof_rdy  in  1  at least one complete frame is buffered.
- fifo_rd_en  out  1  pop strobe; asserted only when fifo_empty is low.
- ll_data  out  32  LocalLink data.
- ll_sof_n  out  1  start of frame, active-low.
- ll_eof_n  out  1  end of frame, active-low.
- ll_src_rdy_n  out  1  source ready, active-low.
- ll_dst_rdy_n  in  1  destination ready, active-low.
- ll_err  out  1  error qualifier; valid only on the eof beat.
- frm_cnt  out  C_CNT_WIDTH  frames delivered; wraps.
- drop_cnt  out  C_CNT_WIDTH  frames discarded or truncated; wraps.

## Operation
- Output register holds one beat. A beat transfers when ll_src_rdy_n=0 and ll_dst_rdy_n=0.
- Pop rule: fifo_rd_en = !fifo_empty && (state is XFER or DRAIN) && (output empty || beat transfers this cycle). In DRAIN, popping does not depend on the output register.
- States:
  - IDLE: if fifo_empty, stay. If the head word has sof=0, go to DRAIN and increment drop_cnt. If the head word has sof=1 and the start gate is true, go to XFER.
  - XFER: each popped word is loaded into the output register, and the word counter increments.
    - Popped word has eof=1: ll_eof_n=0 and ll_err=crc_err. Go to WAIT_ACK.
    - Popped word has sof=1 and is not the first word: no pop occurs. Emit the already-registered word with eof forced and ll_err=1, increment drop_cnt, go to WAIT_ACK. The new frame starts from IDLE.
    - Word counter reaches C_MAX_WORDS without eof: emit that word with eof forced and ll_err=1, increment drop_cnt, go to DRAIN_ACK.
  - WAIT_ACK: when the eof beat transfers, go to IDLE and increment frm_cnt. A truncated frame counts in frm_cnt and in drop_cnt.
  - DRAIN_ACK: when the eof beat transfers, go to DRAIN.
  - DRAIN: pop and discard words until a word with eof=1 is popped, then go to IDLE. Nothing is emitted.
- Start gate: fifo_eof_rdy. With cut-through enabled, the gate is fifo_eof_rdy || !fifo_almost_empty.
- The word counter is 16 bits and is cleared in IDLE.
- Counters wrap modulo 2^C_CNT_WIDTH.

## Timing
- Reset values:
  - ll_src_rdy_n, ll_sof_n and ll_eof_n are 1.
  - ll_err, ll_data, frm_cnt, drop_cnt and fifo_rd_en are 0.
  - State is IDLE.
- Latency: a word popped in cycle N is presented at the LocalLink output in cycle N+1.
- IDLE to XFER decision: one cycle. The first pop occurs in the cycle after the gate is seen true.
- Throughput: one word per cycle while ll_dst_rdy_n=0 and the FIFO is non-empty.
- ll_data and the framing bits are stable while ll_src_rdy_n=0 and ll_dst_rdy_n=1.
- FIFO empty mid-frame: ll_src_rdy_n goes high after the pending beat transfers. The frame resumes when data arrives; no timeout.
- Reset mid-frame: all outputs return to reset values immediately, and no eof is emitted. The FIFO is reset by the same rst, so no partial frame is left in it.

## Configuration
- RXLL_CUT_THROUGH_EN defined: a frame may start once !fifo_almost_empty, before its eof is buffered.
- Not defined: a frame starts only on fifo_eof_rdy (store-and-forward), and fifo_almost_empty is unused.

## Structure
- Shared package holds:
  - bit-position constants RXLL_SOF_BIT=35, RXLL_EOF_BIT=34, RXLL_CRC_BIT=33;
  - state encoding IDLE, XFER, WAIT_ACK, DRAIN_ACK, DRAIN.
- Sub-module ll_out_reg: the one-beat LocalLink output register with hold-on-backpressure. The FSM and counters live in rxll_ll.

## Test plan
- Store-and-forward, 3-word frame (sof on word 0, eof on word 2, fifo_eof_rdy=1, ll_dst_rdy_n=0): 3 beats on consecutive cycles, sof_n=0 on beat 0, eof_n=0 on beat 2, ll_err=0, frm_cnt=1.
- Same frame with crc_err=1 on word 2 and ll_dst_rdy_n toggling 1,0: beats held stable, ll_err=1 on the eof beat, frm_cnt=1, drop_cnt=0.
- Head word 0x1234 with sof=0, followed by a word with eof=1: no LocalLink beats, 2 pops, drop_cnt=1, state returns to IDLE.
- 2050-word frame with C_MAX_WORDS=2049: beat 2049 has eof_n=0 and ll_err=1; the remaining word is drained; frm_cnt=1, drop_cnt=1.
- rst asserted for 1 cycle during word 5 of a 10-word frame: outputs at reset values in the same cycle, counters are 0, and the next frame starts cleanly.
- Cut-through enabled, fifo_eof_rdy=0, fifo_almost_empty falls to 0: first pop occurs within 2 cycles. With the macro undefined, the same stimulus gives no pop until fifo_eof_rdy=1.

Source files
------------

// File: rtl/rxll_ll_pkg.sv
// Shared definitions for the receive LocalLink source stage: FIFO word bit
// positions, FSM state encoding and the one-beat LocalLink record.
package rxll_ll_pkg;

  localparam int RXLL_SOF_BIT  = 35;
  localparam int RXLL_EOF_BIT  = 34;
  localparam int RXLL_CRC_BIT  = 33;
  localparam int RXLL_RSVD_BIT = 32;
  localparam int RXLL_WCNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    XFER,
    WAIT_ACK,
    DRAIN_ACK,
    DRAIN
  } rxll_state_e;

  // One LocalLink beat with active-high framing; the output register inverts.
  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    logic        err;
  } ll_beat_t;

endpackage

// File: rtl/rxll_ll_out_reg.sv
// One-beat LocalLink output register. Holds its beat under backpressure and
// can re-flag the held (or last sent) word as an error-terminated eof beat.
module rxll_ll_out_reg
  import rxll_ll_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  ll_beat_t    beat,
  input  logic        force_eof,
  input  logic        ll_dst_rdy_n,
  output logic [31:0] ll_data,
  output logic        ll_sof_n,
  output logic        ll_eof_n,
  output logic        ll_src_rdy_n,
  output logic        ll_err,
  output logic        full,
  output logic        xfer
);

  assign full = !ll_src_rdy_n;
  assign xfer = !ll_src_rdy_n && !ll_dst_rdy_n;

  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; a blocking = would leak new values into later lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ll_data      <= '0;
      ll_sof_n     <= 1'b1;
      ll_eof_n     <= 1'b1;
      ll_src_rdy_n <= 1'b1;
      ll_err       <= 1'b0;
    end else if (load) begin
      ll_data      <= beat.data;
      ll_sof_n     <= !beat.sof;
      ll_eof_n     <= !beat.eof;
      ll_err       <= beat.err;
      ll_src_rdy_n <= 1'b0;
    end else if (force_eof) begin
      // A beat still waiting keeps its sof; one already gone is re-sent
      // as a plain continuation word that closes the frame with an error.
      if (!full || xfer) begin
        ll_sof_n <= 1'b1;
      end
      ll_eof_n     <= 1'b0;
      ll_err       <= 1'b1;
      ll_src_rdy_n <= 1'b0;
    end else if (xfer) begin
      ll_src_rdy_n <= 1'b1;
    end
  end

endmodule

// File: rtl/rxll_ll.sv
// Receive-side LocalLink source: pops FWFT link-layer FIFO words and emits
// gated, length-checked frames. Define RXLL_CUT_THROUGH_EN for cut-through.
module rxll_ll
  import rxll_ll_pkg::*;
#(
  parameter int C_MAX_WORDS = 2049,
  parameter int C_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [35:0]            fifo_do,
  input  logic                   fifo_empty,
  input  logic                   fifo_almost_empty,
  input  logic                   fifo_eof_rdy,
  output logic                   fifo_rd_en,
  output logic [31:0]            ll_data,
  output logic                   ll_sof_n,
  output logic                   ll_eof_n,
  output logic                   ll_src_rdy_n,
  input  logic                   ll_dst_rdy_n,
  output logic                   ll_err,
  output logic [C_CNT_WIDTH-1:0] frm_cnt,
  output logic [C_CNT_WIDTH-1:0] drop_cnt
);

  localparam logic [RXLL_WCNT_W-1:0] MAX_WORDS = RXLL_WCNT_W'(C_MAX_WORDS);

  rxll_state_e            state;
  logic [RXLL_WCNT_W-1:0] word_cnt;
  logic [RXLL_WCNT_W-1:0] word_next;
  logic                   head_sof;
  logic                   head_eof;
  logic                   head_crc;
  logic                   start_gate;
  logic                   collide;
  logic                   at_max;
  logic                   out_full;
  logic                   out_xfer;
  logic                   out_free;
  logic                   load;
  ll_beat_t               beat;
  logic                   unused_ok;

  assign head_sof  = fifo_do[RXLL_SOF_BIT];
  assign head_eof  = fifo_do[RXLL_EOF_BIT];
  assign head_crc  = fifo_do[RXLL_CRC_BIT];
  assign unused_ok = ^{fifo_do[RXLL_RSVD_BIT], fifo_almost_empty};

`ifdef RXLL_CUT_THROUGH_EN
  assign start_gate = fifo_eof_rdy || !fifo_almost_empty;
`else
  assign start_gate = fifo_eof_rdy;
`endif

  assign out_free  = !out_full || out_xfer;
  assign word_next = word_cnt + 1'b1;
  assign at_max    = (word_next == MAX_WORDS);

  // A sof at the head after the first word means the current frame lost its eof.
  assign collide = (state == XFER) && !fifo_empty && head_sof && (word_cnt != '0);

  // NOTE: a default before the case keeps this block purely combinational;
  // any path that skipped the assignment would infer a latch.
  always_comb begin
    fifo_rd_en = 1'b0;
    unique case (state)
      XFER:    fifo_rd_en = !fifo_empty && out_free && !collide;
      DRAIN:   fifo_rd_en = !fifo_empty;
      default: fifo_rd_en = 1'b0;
    endcase
  end

  assign load = (state == XFER) && fifo_rd_en;

  always_comb begin
    beat.data = fifo_do[31:0];
    beat.sof  = head_sof;
    beat.eof  = head_eof || at_max;
    beat.err  = head_eof ? head_crc : at_max;
  end

  rxll_ll_out_reg u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .beat         (beat),
    .force_eof    (collide),
    .ll_dst_rdy_n (ll_dst_rdy_n),
    .ll_data      (ll_data),
    .ll_sof_n     (ll_sof_n),
    .ll_eof_n     (ll_eof_n),
    .ll_src_rdy_n (ll_src_rdy_n),
    .ll_err       (ll_err),
    .full         (out_full),
    .xfer         (out_xfer)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      frm_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          word_cnt <= '0;
          if (!fifo_empty) begin
            if (!head_sof) begin
              drop_cnt <= drop_cnt + 1'b1;
              state    <= DRAIN;
            end else if (start_gate) begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (collide) begin
            drop_cnt <= drop_cnt + 1'b1;
            state    <= WAIT_ACK;
          end else if (fifo_rd_en) begin
            word_cnt <= word_next;
            if (head_eof) begin
              state <= WAIT_ACK;
            end else if (at_max) begin
              drop_cnt <= drop_cnt + 1'b1;
              state    <= DRAIN_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (out_xfer) begin
            frm_cnt <= frm_cnt + 1'b1;
            state   <= IDLE;
          end
        end
        DRAIN_ACK: begin
          if (out_xfer) begin
            frm_cnt <= frm_cnt + 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_rd_en && head_eof) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rxll_ll.sv
// Randomized bench for rxll_ll: a queue-based FIFO model feeds frames and a
// frame-level reference predicts every LocalLink beat and both counters.
module tb_rxll_ll;

  localparam int MAXW     = 2049;
  localparam int CW       = 16;
  localparam int AE_LEVEL = 4;

  typedef struct {
    logic [31:0] data;
    bit          sof;
    bit          eof;
    bit          err;
  } exp_beat_t;

  typedef enum int {DST_READY, DST_TOGGLE, DST_RANDOM, DST_STALL} dst_mode_e;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [35:0]   fifo_do = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_almost_empty = 1'b1;
  logic          fifo_eof_rdy = 1'b0;
  logic          fifo_rd_en;
  logic [31:0]   ll_data;
  logic          ll_sof_n;
  logic          ll_eof_n;
  logic          ll_src_rdy_n;
  logic          ll_dst_rdy_n = 1'b1;
  logic          ll_err;
  logic [CW-1:0] frm_cnt;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  rxll_ll #(.C_MAX_WORDS(MAXW), .C_CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_do           (fifo_do),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_eof_rdy      (fifo_eof_rdy),
    .fifo_rd_en        (fifo_rd_en),
    .ll_data           (ll_data),
    .ll_sof_n          (ll_sof_n),
    .ll_eof_n          (ll_eof_n),
    .ll_src_rdy_n      (ll_src_rdy_n),
    .ll_dst_rdy_n      (ll_dst_rdy_n),
    .ll_err            (ll_err),
    .frm_cnt           (frm_cnt),
    .drop_cnt          (drop_cnt)
  );

  logic [35:0] fifo_q[$];
  exp_beat_t   exp_q[$];
  int          beat_cyc[$];
  int          eof_cnt  = 0;
  int          exp_frm  = 0;
  int          exp_drop = 0;
  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          cyc      = 0;
  int          pops     = 0;
  int          beats    = 0;
  bit          hold_valid  = 1'b0;
  bit          hold_chk_en = 1'b1;
  logic [34:0] hold_val = '0;
  dst_mode_e   dst_mode = DST_READY;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    fifo_empty        = (fifo_q.size() == 0);
    fifo_do           = fifo_empty ? {4'($urandom), 32'($urandom)} : fifo_q[0];
    fifo_eof_rdy      = (eof_cnt > 0);
    fifo_almost_empty = (fifo_q.size() < AE_LEVEL);
  endtask

  task automatic push_word(input logic [31:0] d, input bit sof, input bit eof, input bit crc);
    fifo_q.push_back({sof, eof, crc, 1'($urandom), d});
    if (eof) eof_cnt++;
    drive();
  endtask

  task automatic push_exp(input logic [31:0] d, input bit sof, input bit eof, input bit err);
    exp_beat_t e;
    e.data = d;
    e.sof  = sof;
    e.eof  = eof;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Reference: a good frame delivers its first MAXW words, closing with its
  // own crc flag or a forced error eof; a frame not led by sof is dropped.
  task automatic push_frame(input int n, input bit crc, input bit junk);
    logic [31:0] d;
    bit          last;
    bit          sof;
    for (int i = 0; i < n; i++) begin
      d    = $urandom;
      last = (i == n - 1);
      sof  = junk ? (i != 0 && $urandom_range(0, 3) == 0) : (i == 0);
      push_word(d, sof, last, last ? crc : 1'($urandom));
      if (!junk && i < MAXW)
        push_exp(d, i == 0, last || (i == MAXW - 1), last ? crc : (i == MAXW - 1));
    end
    if (junk) begin
      exp_drop++;
    end else begin
      exp_frm++;
      if (n > MAXW) exp_drop++;
    end
  endtask

  task automatic step();
    logic      pop;
    logic      xfer;
    exp_beat_t e;
    @(negedge clk);
    cyc++;
    xfer = !ll_src_rdy_n && !ll_dst_rdy_n;
    if (hold_valid && hold_chk_en) begin
      check("hold_src_rdy", ll_src_rdy_n, 0);
      check("hold_beat", {ll_data, ll_sof_n, ll_eof_n, ll_err}, hold_val);
    end
    hold_valid = !ll_src_rdy_n && ll_dst_rdy_n;
    hold_val   = {ll_data, ll_sof_n, ll_eof_n, ll_err};
    pop = fifo_rd_en;
    if (pop) begin
      check("pop_when_empty", fifo_empty, 0);
      pops++;
    end
    if (xfer) begin
      beats++;
      beat_cyc.push_back(cyc);
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", ll_data, e.data);
        check("beat_sof_eof", {!ll_sof_n, !ll_eof_n}, {e.sof, e.eof});
        if (e.eof) check("beat_err", ll_err, e.err);
      end
    end
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() != 0) begin
      if (fifo_q[0][34]) eof_cnt--;
      void'(fifo_q.pop_front());
    end
    case (dst_mode)
      DST_READY:  ll_dst_rdy_n = 1'b0;
      DST_TOGGLE: ll_dst_rdy_n = !ll_dst_rdy_n;
      DST_RANDOM: ll_dst_rdy_n = ($urandom_range(0, 99) < 35);
      default:    ll_dst_rdy_n = 1'b1;
    endcase
    drive();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || !ll_src_rdy_n) && n < budget) begin
      step();
      n++;
    end
    check(tag, n < budget, 1);
    repeat (3) step();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frm_cnt"}, frm_cnt, CW'(exp_frm));
    check({tag, "_drop_cnt"}, drop_cnt, CW'(exp_drop));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_src_rdy_n"}, ll_src_rdy_n, 1);
    check({tag, "_sof_eof_n"}, {ll_sof_n, ll_eof_n}, 2'b11);
    check({tag, "_err_data"}, {ll_err, ll_data}, 0);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_counters"}, {frm_cnt, drop_cnt}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    int          b0;
    int          bc0;
    int          n;
    logic [31:0] d;

    drive();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Store-and-forward 3-word frame with the sink always ready.
    dst_mode = DST_READY;
    step();
    bc0 = beat_cyc.size();
    push_frame(3, 1'b0, 1'b0);
    run_until_done(50, "t1_done");
    check("t1_beats", beat_cyc.size() - bc0, 3);
    if (beat_cyc.size() - bc0 >= 3)
      check("t1_consecutive", beat_cyc[bc0 + 2] - beat_cyc[bc0], 2);
    check_counts("t1");

    // crc error on the eof word, sink toggling not-ready/ready.
    dst_mode = DST_TOGGLE;
    ll_dst_rdy_n = 1'b0;
    push_frame(3, 1'b1, 1'b0);
    run_until_done(50, "t2_done");
    check_counts("t2");

    // Head word without sof: the whole fragment is drained silently.
    dst_mode = DST_READY;
    p0 = pops;
    b0 = beats;
    push_word(32'h0000_1234, 1'b0, 1'b0, 1'b0);
    push_word($urandom, 1'b0, 1'b1, 1'b0);
    exp_drop++;
    run_until_done(50, "t3_done");
    check("t3_pops", pops - p0, 2);
    check("t3_beats", beats - b0, 0);
    check_counts("t3");

    // Oversize frame: truncated at MAXW words with an error eof.
    push_frame(MAXW + 1, 1'b0, 1'b0);
    run_until_done(MAXW + 200, "t4_done");
    check_counts("t4");

    // Frame missing its eof, followed by a new sof while the sink stalls.
    hold_chk_en = 1'b0;
    dst_mode = DST_STALL;
    ll_dst_rdy_n = 1'b1;
    p0 = pops;
    b0 = beats;
    d = $urandom;
    push_word(d, 1'b1, 1'b0, 1'b0);
    push_exp(d, 1'b1, 1'b1, 1'b1);
    exp_frm++;
    exp_drop++;
    push_frame(3, 1'b0, 1'b0);
    repeat (6) step();
    check("t5_stall_pops", pops - p0, 1);
    check("t5_stall_beats", beats - b0, 0);
    dst_mode = DST_READY;
    run_until_done(100, "t5_done");
    hold_chk_en = 1'b1;
    check_counts("t5");

    // Start gate with no eof buffered but the FIFO above almost-empty.
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      push_word(d, i == 0, 1'b0, 1'b0);
      push_exp(d, i == 0, 1'b0, 1'b0);
    end
`ifdef RXLL_CUT_THROUGH_EN
    repeat (2) step();
    check("t6_ct_first_pop", (pops - p0) > 0, 1);
`else
    repeat (10) step();
    check("t6_sf_no_pop", pops - p0, 0);
`endif
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      push_word(d, 1'b0, i == 1, 1'b0);
      push_exp(d, 1'b0, i == 1, 1'b0);
    end
    exp_frm++;
    run_until_done(200, "t6_done");
    check("t6_pops", pops - p0, 8);
    check_counts("t6");

    // Randomized traffic: good frames, crc errors, fragments, random backpressure.
    dst_mode = DST_RANDOM;
    for (int c = 0; c < 4000; c++) begin
      if (fifo_q.size() < 32 && $urandom_range(0, 3) == 0)
        push_frame($urandom_range(1, 24), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15));
      step();
    end
    run_until_done(3000, "rand_done");
    check("rand_exp_left", exp_q.size(), 0);
    check_counts("rand");

    // Reset while word 5 of a 10-word frame is on the bus.
    dst_mode = DST_READY;
    b0 = beats;
    push_frame(10, 1'b0, 1'b0);
    n = 0;
    while (beats - b0 < 4 && n < 50) begin
      step();
      n++;
    end
    check("t7_reach_word5", n < 50, 1);
    check("t7_mid_frame", ll_src_rdy_n, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("t7_rst");
    fifo_q.delete();
    exp_q.delete();
    eof_cnt    = 0;
    exp_frm    = 0;
    exp_drop   = 0;
    hold_valid = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(4, 1'b0, 1'b0);
    run_until_done(50, "t7_done");
    check_counts("t7_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
